output_periph: RTL and testbench
================================

OUTPUT_PERIPH -- requirements
Module: output_periph

Interface
REQ-001 SHALL provide ports: clk, in, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL provide ports: rst_n, in, 1, synchronous active-high reset, asserted when 1 despite the suffix.
REQ-003 SHALL provide ports: addr, in, 8, byte address; addr[1:0] ignored, word select = addr[7:2].
REQ-004 SHALL provide ports: w_data, in, 32, write data.
REQ-005 SHALL provide ports: wr_en, in, 1, write strobe, sampled on clk rising edge.
REQ-006 SHALL provide ports: bmask, in, 4, byte-lane write enables, bit i = w_data[8i+7:8i].
REQ-007 SHALL provide ports: rd_data, out, 32, combinational readback of addressed register.
REQ-008 SHALL provide ports: io_hex0..io_hex7, out, 7 each, seven-segment patterns.
REQ-009 SHALL provide ports: io_ledr, io_ledg, io_lcd, out, 32 each, register contents.

Function
REQ-010 SHALL decode the address map:
- 0x00 LEDR (32b)
- 0x10 LEDG (32b)
- 0x20 HEX_LO: byte0=hex0, byte1=hex1, byte2=hex2, byte3=hex3
- 0x24 HEX_HI: byte0=hex4 .. byte3=hex7
- 0x30 LCD (32b)
- all other addresses unmapped.
REQ-011 SHALL, on a rising edge with wr_en=1 and a mapped address, update only the byte lanes whose bmask bit is 1; other lanes hold.
REQ-012 SHALL store only bits [6:0] of each HEX byte lane; bit 7 is discarded.
REQ-013 SHALL ignore writes to unmapped addresses and writes with bmask=0000.
REQ-014 SHALL drive rd_data combinationally (zero-cycle latency) from the register selected by addr, regardless of wr_en.
REQ-015 SHALL return HEX registers as {1'b0,hexN+3,1'b0,hexN+2,1'b0,hexN+1,1'b0,hexN}.
REQ-016 SHALL return 0x00000000 for unmapped addresses.
REQ-017 SHALL drive each output port directly from its storage register, with new values visible one edge after the write.
REQ-018 SHALL, on simultaneous read and write to the same address, show the old value on rd_data until the edge and the new value after it.

Reset
REQ-019 SHALL clear LEDR, LEDG, LCD and all eight HEX registers to 0 on a rising edge with rst_n=1.
REQ-020 SHALL, while reset is high, give reset priority over any concurrent write.
REQ-021 SHALL drive rd_data from reset register values (0 for all mapped addresses) immediately after reset.

Configuration
REQ-022 SHALL compile the LCD register only when OUTPUT_PERIPH_LCD_EN is defined.
REQ-023 SHALL, with the macro undefined:
- tie io_lcd to 0
- treat 0x30 as unmapped (writes ignored, reads 0)
- remove all LCD storage.

Verification
REQ-024 SHALL pass: after reset, write 0x00001234 to 0x00 with bmask=0011 -> io_ledr=0x00001234; read 0x00 returns 0x00001234.
REQ-025 SHALL pass: write 0xCAFEBABE to 0x20 with bmask=0011 -> io_hex0=0x3E, io_hex1=0x3A, io_hex2=0x00, io_hex3=0x00; read 0x20 returns 0x00003A3E.
REQ-026 SHALL pass: write 0xB0BACAFE to 0x24 with bmask=1111 -> io_hex4=0x7E, io_hex5=0x4A, io_hex6=0x3A, io_hex7=0x30; read 0x24 returns 0x303A4A7E.
REQ-027 SHALL pass: write 0xFFFFFFFF to 0x10 with wr_en=0, then to 0x44 with wr_en=1 -> all outputs unchanged; read 0x44 returns 0.
REQ-028 SHALL pass: assert rst_n=1 in the same cycle as a write of 0x55 to 0x00 -> io_ledr=0 after the edge.
REQ-029 SHALL pass with the macro defined: write 0x12345678 to 0x30 with bmask=1111 -> io_lcd=0x12345678. With it undefined: io_lcd stays 0 and read 0x30 returns 0.

Source files
------------

// File: rtl/output_periph.sv
// Memory-mapped output peripheral: LED, seven-segment and optional LCD registers with byte-lane writes.
// Optional LCD register is compiled only when OUTPUT_PERIPH_LCD_EN is defined.

module output_periph_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (we)
            q <= d;
    end
endmodule

module output_periph (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  addr,
    input  logic [31:0] w_data,
    input  logic        wr_en,
    input  logic [3:0]  bmask,
    output logic [31:0] rd_data,
    output logic [6:0]  io_hex0,
    output logic [6:0]  io_hex1,
    output logic [6:0]  io_hex2,
    output logic [6:0]  io_hex3,
    output logic [6:0]  io_hex4,
    output logic [6:0]  io_hex5,
    output logic [6:0]  io_hex6,
    output logic [6:0]  io_hex7,
    output logic [31:0] io_ledr,
    output logic [31:0] io_ledg,
    output logic [31:0] io_lcd
);
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int HEX_W     = 7;
    localparam int NUM_HEX   = 8;

    localparam logic [5:0] W_LEDR   = 6'h00;
    localparam logic [5:0] W_LEDG   = 6'h04;
    localparam logic [5:0] W_HEX_LO = 6'h08;
    localparam logic [5:0] W_HEX_HI = 6'h09;
    localparam logic [5:0] W_LCD    = 6'h0C;

    typedef struct packed {
        logic [5:0]           word;
        logic [NUM_LANES-1:0] lanes;
    } wr_req_t;

    wr_req_t req;
    logic [NUM_LANES-1:0][LANE_W-1:0] wdata_b;
    logic [NUM_LANES-1:0] we_ledr, we_ledg, we_hex_lo, we_hex_hi, we_lcd;
    logic [NUM_LANES-1:0][LANE_W-1:0] ledr_q, ledg_q, lcd_q;
    logic [NUM_HEX-1:0][HEX_W-1:0] hex_q;
    logic unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];
    assign wdata_b = w_data;

    // Write strobe folded into lane enables, so bmask=0 or wr_en=0 writes nothing.
    always_comb begin
        req.word  = addr[7:2];
        req.lanes = wr_en ? bmask : '0;
        we_ledr   = (req.word == W_LEDR)   ? req.lanes : '0;
        we_ledg   = (req.word == W_LEDG)   ? req.lanes : '0;
        we_hex_lo = (req.word == W_HEX_LO) ? req.lanes : '0;
        we_hex_hi = (req.word == W_HEX_HI) ? req.lanes : '0;
`ifdef OUTPUT_PERIPH_LCD_EN
        we_lcd    = (req.word == W_LCD)    ? req.lanes : '0;
`else
        we_lcd    = '0;
`endif
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            output_periph_lane #(.W(LANE_W)) u_ledr (
                .clk(clk), .rst(rst_n), .we(we_ledr[g]), .d(wdata_b[g]), .q(ledr_q[g])
            );
            output_periph_lane #(.W(LANE_W)) u_ledg (
                .clk(clk), .rst(rst_n), .we(we_ledg[g]), .d(wdata_b[g]), .q(ledg_q[g])
            );
            // HEX lanes keep only the 7 segment bits; bit 7 of each byte is dropped.
            output_periph_lane #(.W(HEX_W)) u_hex_lo (
                .clk(clk), .rst(rst_n), .we(we_hex_lo[g]), .d(wdata_b[g][HEX_W-1:0]), .q(hex_q[g])
            );
            output_periph_lane #(.W(HEX_W)) u_hex_hi (
                .clk(clk), .rst(rst_n), .we(we_hex_hi[g]), .d(wdata_b[g][HEX_W-1:0]),
                .q(hex_q[g+NUM_LANES])
            );
`ifdef OUTPUT_PERIPH_LCD_EN
            output_periph_lane #(.W(LANE_W)) u_lcd (
                .clk(clk), .rst(rst_n), .we(we_lcd[g]), .d(wdata_b[g]), .q(lcd_q[g])
            );
`else
            assign lcd_q[g] = '0;
`endif
        end
    endgenerate

    function automatic logic [31:0] hex_word(input logic [NUM_LANES-1:0][HEX_W-1:0] h);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < NUM_LANES; i++)
            w[i*LANE_W +: LANE_W] = {1'b0, h[i]};
        return w;
    endfunction

    always_comb begin
        rd_data = '0;
        case (addr[7:2])
            W_LEDR:   rd_data = ledr_q;
            W_LEDG:   rd_data = ledg_q;
            W_HEX_LO: rd_data = hex_word(hex_q[3:0]);
            W_HEX_HI: rd_data = hex_word(hex_q[7:4]);
`ifdef OUTPUT_PERIPH_LCD_EN
            W_LCD:    rd_data = lcd_q;
`endif
            default:  rd_data = '0;
        endcase
    end

    assign io_ledr = ledr_q;
    assign io_ledg = ledg_q;
    assign io_lcd  = lcd_q;
    assign io_hex0 = hex_q[0];
    assign io_hex1 = hex_q[1];
    assign io_hex2 = hex_q[2];
    assign io_hex3 = hex_q[3];
    assign io_hex4 = hex_q[4];
    assign io_hex5 = hex_q[5];
    assign io_hex6 = hex_q[6];
    assign io_hex7 = hex_q[7];
endmodule

// File: tb/tb_output_periph.sv
// Directed scoreboard bench for output_periph: expectations queued per step, drained after the edge.
// Follows OUTPUT_PERIPH_LCD_EN to pick the LCD expectations.

module tb_output_periph;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [31:0] w_data;
    logic        wr_en;
    logic [3:0]  bmask;
    logic [31:0] rd_data;
    logic [6:0]  io_hex0, io_hex1, io_hex2, io_hex3, io_hex4, io_hex5, io_hex6, io_hex7;
    logic [31:0] io_ledr, io_ledg, io_lcd;

    int tests = 0;
    int fails = 0;

    localparam int K_LEDR = 0, K_LEDG = 1, K_LCD = 2, K_HEX0 = 3, K_RD = 11;

    int          kind_q[$];
    logic [7:0]  addr_q[$];
    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [31:0] m_ledr, m_ledg, m_lcd;
    logic [6:0]  m_hex[8];

    output_periph dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .w_data(w_data), .wr_en(wr_en), .bmask(bmask),
        .rd_data(rd_data),
        .io_hex0(io_hex0), .io_hex1(io_hex1), .io_hex2(io_hex2), .io_hex3(io_hex3),
        .io_hex4(io_hex4), .io_hex5(io_hex5), .io_hex6(io_hex6), .io_hex7(io_hex7),
        .io_ledr(io_ledr), .io_ledg(io_ledg), .io_lcd(io_lcd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int k);
        case (k)
            K_LEDR: return io_ledr;
            K_LEDG: return io_ledg;
            K_LCD:  return io_lcd;
            3:  return {25'b0, io_hex0};
            4:  return {25'b0, io_hex1};
            5:  return {25'b0, io_hex2};
            6:  return {25'b0, io_hex3};
            7:  return {25'b0, io_hex4};
            8:  return {25'b0, io_hex5};
            9:  return {25'b0, io_hex6};
            10: return {25'b0, io_hex7};
            default: return rd_data;
        endcase
    endfunction

    task automatic push(input string tag, input int k, input logic [7:0] a, input logic [31:0] e);
        tag_q.push_back(tag);
        kind_q.push_back(k);
        addr_q.push_back(a);
        exp_q.push_back(e);
    endtask

    task automatic push_outputs(input string step);
        push({step, ".ledr"}, K_LEDR, 8'h00, m_ledr);
        push({step, ".ledg"}, K_LEDG, 8'h00, m_ledg);
        push({step, ".lcd"},  K_LCD,  8'h00, m_lcd);
        for (int i = 0; i < 8; i++)
            push($sformatf("%s.hex%0d", step, i), K_HEX0 + i, 8'h00, {25'b0, m_hex[i]});
    endtask

    task automatic drain();
        int k; logic [7:0] a; logic [31:0] e; logic [31:0] obs; string t;
        while (exp_q.size() > 0) begin
            k = kind_q.pop_front();
            a = addr_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (k == K_RD) begin
                addr = a;
                #1;
            end
            obs = observe(k);
            tests++;
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic write_cycle(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m,
                               input logic en);
        @(negedge clk);
        addr = a; w_data = d; bmask = m; wr_en = en;
        @(posedge clk);
        #1;
        wr_en = 1'b0; bmask = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b1; addr = 8'h00; w_data = 32'h0; wr_en = 1'b0; bmask = 4'h0;
        m_ledr = 0; m_ledg = 0; m_lcd = 0;
        for (int i = 0; i < 8; i++) m_hex[i] = 7'h00;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        push_outputs("reset");
        push("reset.rd00", K_RD, 8'h00, 32'h0);
        push("reset.rd10", K_RD, 8'h10, 32'h0);
        push("reset.rd20", K_RD, 8'h20, 32'h0);
        push("reset.rd24", K_RD, 8'h24, 32'h0);
        push("reset.rd30", K_RD, 8'h30, 32'h0);
        drain();

        // LEDR partial write
        write_cycle(8'h00, 32'h0000_1234, 4'b0011, 1'b1);
        m_ledr = 32'h0000_1234;
        push_outputs("ledr");
        push("ledr.rd", K_RD, 8'h00, 32'h0000_1234);
        drain();

        // HEX_LO lanes 0/1, bit 7 discarded
        write_cycle(8'h20, 32'hCAFE_BABE, 4'b0011, 1'b1);
        m_hex[0] = 7'h3E; m_hex[1] = 7'h3A;
        push_outputs("hexlo");
        push("hexlo.rd", K_RD, 8'h20, 32'h0000_3A3E);
        drain();

        // HEX_HI full write
        write_cycle(8'h24, 32'hB0BA_CAFE, 4'b1111, 1'b1);
        m_hex[4] = 7'h7E; m_hex[5] = 7'h4A; m_hex[6] = 7'h3A; m_hex[7] = 7'h30;
        push_outputs("hexhi");
        push("hexhi.rd", K_RD, 8'h24, 32'h303A_4A7E);
        push("hexhi.rd_lowbits", K_RD, 8'h27, 32'h303A_4A7E);
        drain();

        // wr_en=0, unmapped address, bmask=0 all ignored
        write_cycle(8'h10, 32'hFFFF_FFFF, 4'b1111, 1'b0);
        write_cycle(8'h44, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        write_cycle(8'h00, 32'hFFFF_FFFF, 4'b0000, 1'b1);
        push_outputs("ignored");
        push("ignored.rd44", K_RD, 8'h44, 32'h0);
        push("ignored.rd00", K_RD, 8'h00, 32'h0000_1234);
        drain();

        // LEDG byte-lane merge
        write_cycle(8'h10, 32'hAABB_CCDD, 4'b1111, 1'b1);
        write_cycle(8'h12, 32'h1122_3344, 4'b1010, 1'b1);
        m_ledg = 32'h11BB_33DD;
        push_outputs("ledg_merge");
        push("ledg_merge.rd", K_RD, 8'h10, 32'h11BB_33DD);
        drain();

        // read-during-write: old value before the edge, new after
        @(negedge clk);
        addr = 8'h10; w_data = 32'h5566_7788; bmask = 4'b1111; wr_en = 1'b1;
        #1;
        push("rdw.before", K_RD, 8'h10, 32'h11BB_33DD);
        drain();
        @(posedge clk);
        #1;
        wr_en = 1'b0; bmask = 4'b0000;
        m_ledg = 32'h5566_7788;
        push("rdw.after", K_RD, 8'h10, 32'h5566_7788);
        drain();

        // LCD register (present only with the macro)
        write_cycle(8'h30, 32'h1234_5678, 4'b1111, 1'b1);
`ifdef OUTPUT_PERIPH_LCD_EN
        m_lcd = 32'h1234_5678;
`else
        m_lcd = 32'h0;
`endif
        push_outputs("lcd");
        push("lcd.rd", K_RD, 8'h30, m_lcd);
        drain();

        // reset wins over a concurrent write
        @(negedge clk);
        rst_n = 1'b1; addr = 8'h00; w_data = 32'h0000_0055; bmask = 4'b1111; wr_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0; wr_en = 1'b0; bmask = 4'b0000;
        m_ledr = 0; m_ledg = 0; m_lcd = 0;
        for (int i = 0; i < 8; i++) m_hex[i] = 7'h00;
        push_outputs("rst_prio");
        push("rst_prio.rd00", K_RD, 8'h00, 32'h0);
        push("rst_prio.rd24", K_RD, 8'h24, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
